// File: rtl/seg_display_pkg.sv
// Shared constants and the hex glyph decoder for the multiplexed 7-segment
// display driver. Glyphs are active-low, bit order {g,f,e,d,c,b,a}.
package seg_display_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] GLYPH_0 = 7'b1000000;
  localparam logic [6:0] GLYPH_1 = 7'b1111001;
  localparam logic [6:0] GLYPH_2 = 7'b0100100;
  localparam logic [6:0] GLYPH_3 = 7'b0110000;
  localparam logic [6:0] GLYPH_4 = 7'b0011001;
  localparam logic [6:0] GLYPH_5 = 7'b0010010;
  localparam logic [6:0] GLYPH_6 = 7'b0000010;
  localparam logic [6:0] GLYPH_7 = 7'b1111000;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0010000;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b0000011;
  localparam logic [6:0] GLYPH_C = 7'b1000110;
  localparam logic [6:0] GLYPH_D = 7'b0100001;
  localparam logic [6:0] GLYPH_E = 7'b0000110;
  localparam logic [6:0] GLYPH_F = 7'b0001110;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0:    seg = GLYPH_0;
      4'h1:    seg = GLYPH_1;
      4'h2:    seg = GLYPH_2;
      4'h3:    seg = GLYPH_3;
      4'h4:    seg = GLYPH_4;
      4'h5:    seg = GLYPH_5;
      4'h6:    seg = GLYPH_6;
      4'h7:    seg = GLYPH_7;
      4'h8:    seg = GLYPH_8;
      4'h9:    seg = GLYPH_9;
      4'hA:    seg = GLYPH_A;
      4'hB:    seg = GLYPH_B;
      4'hC:    seg = GLYPH_C;
      4'hD:    seg = GLYPH_D;
      4'hE:    seg = GLYPH_E;
      default: seg = GLYPH_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Digit-slot timing: slot counter, digit index, end-of-frame pulse and the
// anode on-window (anti-ghosting dead time followed by the PWM on-time).
module seg_scan_timer #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned PRESCALE     = 100000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned BR_W         = 3,
  localparam int unsigned IDX_W       = $clog2(NUM_DIGITS),
  localparam int unsigned CNT_W       = $clog2(PRESCALE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BR_W-1:0]  brightness_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             win_o,
  output logic             frame_done_o
);

  localparam int unsigned ON_SPAN = PRESCALE - BLANK_CYCLES;
  localparam int unsigned STEP    = ON_SPAN >> BR_W;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [BR_W-1:0]  br_q, br_d;
  logic             slot_end;
  logic [31:0]      on_cycles;

  // Next-state for counter/index; brightness is taken live at cnt 0 so the
  // window is right even in the first cycle of a slot, then held.
  always_comb begin
    slot_end = (cnt_q == CNT_W'(PRESCALE - 1));
    cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
    br_d      = (cnt_q == '0) ? brightness_i : br_q;
    on_cycles = (&br_d) ? ON_SPAN : 32'(br_d) * STEP;
    win_o     = (32'(cnt_q) >= BLANK_CYCLES) &&
                (32'(cnt_q) < BLANK_CYCLES + on_cycles);
  end

  // Timer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
      br_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      br_q  <= br_d;
    end
  end

  assign idx_o        = idx_q;
  assign frame_done_o = slot_end && (idx_q == IDX_W'(NUM_DIGITS - 1));

endmodule

// File: rtl/seg_scan_display.sv
// N-digit multiplexed 7-segment driver with tear-free double buffering,
// anti-ghosting dead time and PWM brightness. All pin outputs are active-low
// and registered. Optional build macro SEG_LEADING_ZERO_BLANK_EN adds
// automatic leading-zero blanking when the active buffer is loaded.
module seg_scan_display
  import seg_display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned PRESCALE     = 100000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned BR_W         = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [BR_W-1:0]         brightness,
  output logic [6:0]              segment,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

  logic [IDX_W-1:0] idx;
  logic             win;
  logic             frame_end;

  seg_scan_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .PRESCALE    (PRESCALE),
    .BLANK_CYCLES(BLANK_CYCLES),
    .BR_W        (BR_W)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .brightness_i(brightness),
    .idx_o       (idx),
    .win_o       (win),
    .frame_done_o(frame_end)
  );

  logic [4*NUM_DIGITS-1:0] pend_dig_q, pend_dig_d, act_dig_q, act_dig_d;
  logic [NUM_DIGITS-1:0]   pend_blk_q, pend_blk_d, act_blk_q, act_blk_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic                    pend_vld_q, pend_vld_d;
  logic [NUM_DIGITS-1:0]   in_blk_eff, pend_blk_eff;

`ifdef SEG_LEADING_ZERO_BLANK_EN
  // Zero digits from the top down are darkened until a non-zero digit or a
  // lit decimal point is met; digit 0 always stays visible.
  function automatic logic [NUM_DIGITS-1:0] lz_mask(
    input logic [4*NUM_DIGITS-1:0] d,
    input logic [NUM_DIGITS-1:0]   dp
  );
    logic run;
    lz_mask = '0;
    run     = 1'b1;
    for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
      if (run && (d[4*i +: 4] == 4'h0) && !dp[i]) lz_mask[i] = 1'b1;
      else run = 1'b0;
    end
  endfunction

  assign in_blk_eff   = blank_in | lz_mask(digits_in, dp_in);
  assign pend_blk_eff = pend_blk_q | lz_mask(pend_dig_q, pend_dp_q);
`else
  assign in_blk_eff   = blank_in;
  assign pend_blk_eff = pend_blk_q;
`endif

  // Buffer swap: a load on the frame boundary bypasses pending entirely.
  always_comb begin
    pend_dig_d = pend_dig_q;
    pend_blk_d = pend_blk_q;
    pend_dp_d  = pend_dp_q;
    pend_vld_d = pend_vld_q;
    act_dig_d  = act_dig_q;
    act_blk_d  = act_blk_q;
    act_dp_d   = act_dp_q;
    if (load) begin
      pend_dig_d = digits_in;
      pend_blk_d = blank_in;
      pend_dp_d  = dp_in;
    end
    if (frame_end && load) begin
      act_dig_d  = digits_in;
      act_blk_d  = in_blk_eff;
      act_dp_d   = dp_in;
      pend_vld_d = 1'b0;
    end else if (frame_end && pend_vld_q) begin
      act_dig_d  = pend_dig_q;
      act_blk_d  = pend_blk_eff;
      act_dp_d   = pend_dp_q;
      pend_vld_d = 1'b0;
    end else if (load) begin
      pend_vld_d = 1'b1;
    end
  end

  // Pending and active buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_dig_q <= '0;
      pend_blk_q <= '0;
      pend_dp_q  <= '0;
      pend_vld_q <= 1'b0;
      act_dig_q  <= '0;
      act_blk_q  <= '0;
      act_dp_q   <= '0;
    end else begin
      pend_dig_q <= pend_dig_d;
      pend_blk_q <= pend_blk_d;
      pend_dp_q  <= pend_dp_d;
      pend_vld_q <= pend_vld_d;
      act_dig_q  <= act_dig_d;
      act_blk_q  <= act_blk_d;
      act_dp_q   <= act_dp_d;
    end
  end

  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  dark;

  // Decode the current digit from the active buffer only.
  always_comb begin
    dark  = act_blk_q[idx];
    seg_d = dark ? SEG_OFF : hex_to_seg(act_dig_q[{idx, 2'b00} +: 4]);
    dp_d  = ~(act_dp_q[idx] & ~dark);
    an_d  = '1;
    if (win && !dark) an_d[idx] = 1'b0;
  end

  // Output pin registers, all updated on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= SEG_OFF;
      dp_q  <= 1'b1;
      an_q  <= '1;
    end else begin
      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
    end
  end

  assign segment    = seg_q;
  assign dp_out     = dp_q;
  assign an         = an_q;
  assign frame_done = frame_end;

endmodule

// File: tb/tb_seg_scan_display.sv
module tb_seg_scan_display;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  blank_in = '0;
  logic [3:0]  dp_in = '0;
  logic [2:0]  brightness = 3'd7;
  logic [6:0]  segment;
  logic        dp_out;
  logic [3:0]  an;
  logic        frame_done;

  int vectors = 0;
  int miscompares = 0;
  int k = 0;

  seg_scan_display #(
    .NUM_DIGITS(4), .PRESCALE(16), .BLANK_CYCLES(2), .BR_W(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in),
    .blank_in(blank_in), .dp_in(dp_in), .brightness(brightness),
    .segment(segment), .dp_out(dp_out), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic run_to(input int t);
    while (k < t) step();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] b, input logic [3:0] p);
    digits_in = d;
    blank_in  = b;
    dp_in     = p;
    load      = 1'b1;
    step();
    load      = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                     input logic e_dp);
    vectors++;
    assert ({an, segment, dp_out} === {e_an, e_seg, e_dp})
    else begin
      miscompares++;
      $error("FAIL %s k=%0d an/seg/dp observed %b/%b/%b expected %b/%b/%b",
             tag, k, an, segment, dp_out, e_an, e_seg, e_dp);
    end
  endtask

  task automatic chk_fd(input string tag, input logic e);
    vectors++;
    assert (frame_done === e)
    else begin
      miscompares++;
      $error("FAIL %s k=%0d frame_done observed %b expected %b", tag, k, frame_done, e);
    end
  endtask

  initial begin
    #12;
    chk("reset_outputs", 4'hF, 7'h7F, 1'b1);
    chk_fd("reset_fd", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;

    run_to(1);   chk("f1_cnt0_dark", 4'hF, 7'h40, 1'b1);
    run_to(3);   chk("f1_d0_zero", 4'b1110, 7'h40, 1'b1);
    do_load(16'h1234, 4'h0, 4'h0);
    run_to(62);  chk_fd("fd_before", 1'b0);
    run_to(63);  chk_fd("fd_frame1", 1'b1);
                 chk("f1_d3_old", 4'b0111, 7'h40, 1'b1);
    run_to(64);  chk("f1_last_cycle_old", 4'b0111, 7'h40, 1'b1);
                 chk_fd("fd_after", 1'b0);
    run_to(65);  chk("f2_cnt0_dark", 4'hF, 7'h19, 1'b1);
    run_to(67);  chk("f2_d0_4", 4'b1110, 7'h19, 1'b1);
    run_to(83);  chk("f2_d1_3", 4'b1101, 7'h30, 1'b1);
    run_to(84);  do_load(16'hABCD, 4'h0, 4'h0);
    run_to(99);  chk("f2_d2_old_2", 4'b1011, 7'h24, 1'b1);
    run_to(115); chk("f2_d3_old_1", 4'b0111, 7'h79, 1'b1);
    run_to(127); chk_fd("fd_frame2", 1'b1);
    run_to(131); chk("f3_d0_D", 4'b1110, 7'h21, 1'b1);
    run_to(147); chk("f3_d1_C", 4'b1101, 7'h46, 1'b1);
    run_to(163); chk("f3_d2_b", 4'b1011, 7'h03, 1'b1);
    run_to(179); chk("f3_d3_A", 4'b0111, 7'h08, 1'b1);
    run_to(191); chk_fd("fd_frame3", 1'b1);
    do_load(16'h5678, 4'h0, 4'h0);
    run_to(193); chk("bypass_cnt0", 4'hF, 7'h00, 1'b1);
    run_to(195); chk("bypass_d0_8", 4'b1110, 7'h00, 1'b1);

    run_to(200); brightness = 3'd2;
    run_to(206); chk("br_held_in_slot", 4'b1110, 7'h00, 1'b1);
    run_to(210); chk("br2_cnt1", 4'hF, 7'h78, 1'b1);
    run_to(211); chk("br2_cnt2", 4'b1101, 7'h78, 1'b1);
    run_to(212); chk("br2_cnt3", 4'b1101, 7'h78, 1'b1);
    run_to(213); chk("br2_cnt4", 4'hF, 7'h78, 1'b1);
    run_to(220); brightness = 3'd0;
    run_to(227); chk("br0_cnt2", 4'hF, 7'h02, 1'b1);
    run_to(230); do_load(16'h5678, 4'b0100, 4'b0001);
    run_to(235); chk("br0_cnt10", 4'hF, 7'h02, 1'b1);
    run_to(240); brightness = 3'd7;
    run_to(243); chk("br7_restored", 4'b0111, 7'h12, 1'b1);

    run_to(258); chk("dp_in_dead_time", 4'hF, 7'h00, 1'b0);
    run_to(259); chk("dp_slot0", 4'b1110, 7'h00, 1'b0);
    run_to(275); chk("dp_off_slot1", 4'b1101, 7'h78, 1'b1);
    run_to(291); chk("blank_slot2_a", 4'hF, 7'h7F, 1'b1);
    run_to(299); chk("blank_slot2_b", 4'hF, 7'h7F, 1'b1);
    run_to(300); do_load(16'h5678, 4'h0, 4'h0);
    run_to(307); chk("slot3_5", 4'b0111, 7'h12, 1'b1);

    run_to(356); chk("pre_reset_slot2", 4'b1011, 7'h02, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 4'hF, 7'h7F, 1'b1);
    chk_fd("async_reset_fd", 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    run_to(1);   chk("restart_cnt0", 4'hF, 7'h40, 1'b1);
    run_to(3);   chk("restart_d0", 4'b1110, 7'h40, 1'b1);
    run_to(19);  chk("restart_d1", 4'b1101, 7'h40, 1'b1);

    run_to(20);  do_load(16'h0050, 4'h0, 4'h0);
    run_to(67);  chk("lz_d0", 4'b1110, 7'h40, 1'b1);
    run_to(83);  chk("lz_d1", 4'b1101, 7'h12, 1'b1);
`ifdef SEG_LEADING_ZERO_BLANK_EN
    run_to(99);  chk("lz_d2", 4'hF, 7'h7F, 1'b1);
    run_to(115); chk("lz_d3", 4'hF, 7'h7F, 1'b1);
`else
    run_to(99);  chk("lz_d2", 4'b1011, 7'h40, 1'b1);
    run_to(115); chk("lz_d3", 4'b0111, 7'h40, 1'b1);
`endif
    run_to(130); do_load(16'h1111, 4'h0, 4'h0);
    run_to(140); do_load(16'h0000, 4'h0, 4'h0);
    run_to(195); chk("last_load_d0", 4'b1110, 7'h40, 1'b1);
`ifdef SEG_LEADING_ZERO_BLANK_EN
    run_to(211); chk("last_load_d1", 4'hF, 7'h7F, 1'b1);
`else
    run_to(211); chk("last_load_d1", 4'b1101, 7'h40, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
